// File: rtl/tristate_bus_port.sv
// Registered bidirectional tristate bus port: accepts write beats over valid/ready,
// drives them onto a shared bus from a register, enforces a turnaround gap and burst cap.
module tristate_bus_port #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  inout  logic [WIDTH-1:0] bus,
  output logic             bus_oe,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             burst_trunc,
  output logic             busy
);

  // Unlimited bursts still keep a small saturating counter.
  localparam int unsigned CW = (MAX_BURST == 0) ? 8 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = (MAX_BURST == 0) ? '1 : CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [3:0]       turn_q, turn_d;
  logic             trunc_q, trunc_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             terminal;

  assign terminal = (state_q == DRIVE) &&
                    (last_q || ((MAX_BURST != 0) && (cnt_q == CNT_MAX)));

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    turn_d   = turn_q;
    trunc_d  = 1'b0;
    wr_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          data_d  = wr_data;
          cnt_d   = CW'(1);
          last_d  = wr_last;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (terminal) begin
          // Pulse only when the cap, not wr_last, ended the burst.
          trunc_d = ~last_q;
          turn_d  = 4'(TURN_CYCLES);
          state_d = (TURN_CYCLES == 0) ? IDLE : TURN;
        end else begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            data_d = wr_data;
            cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
            last_d = wr_last;
          end
        end
      end
      TURN: begin
        if (turn_q <= 4'd1) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      turn_q     <= '0;
      trunc_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      turn_q     <= turn_d;
      trunc_q    <= trunc_d;
      rd_data_q  <= bus;
      rd_valid_q <= (state_q != DRIVE);
    end
  end

  assign bus_oe      = (state_q == DRIVE);
  assign bus         = bus_oe ? data_q : 'z;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign burst_trunc = trunc_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tristate_bus_port.sv
// Drives three differently configured ports with shared random/directed beats and
// compares every cycle against a behavioural model of the handshake and bus timeline.
module tb_tristate_bus_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_last;

  wire  [7:0] bus0, bus1, bus2;
  logic [7:0] ext_d  [3];
  logic       ext_en [3];
  logic       ready  [3];
  logic       oe     [3];
  logic       rdv    [3];
  logic       trunc  [3];
  logic       busy   [3];
  logic [7:0] rdd    [3];

  int n_chk = 0;
  int n_bad = 0;

  // Per-instance configuration: {TURN_CYCLES, MAX_BURST}
  int tc [3] = '{1, 0, 3};
  int mb [3] = '{16, 4, 0};

  // Model: whether a beat is on the bus, how many beats so far, remaining Z cycles.
  bit         m_drv   [3];
  int         m_beats [3];
  bit         m_last  [3];
  logic [7:0] m_data  [3];
  int         m_gap   [3];
  bit         m_trunc [3];
  bit         m_rdv   [3];
  logic [7:0] m_rdd   [3];
  bit         m_known [3];

  assign bus0 = ext_en[0] ? ext_d[0] : 'z;
  assign bus1 = ext_en[1] ? ext_d[1] : 'z;
  assign bus2 = ext_en[2] ? ext_d[2] : 'z;

  always #5 clk = ~clk;

  tristate_bus_port #(.WIDTH(8), .TURN_CYCLES(1), .MAX_BURST(16)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready[0]),
    .wr_data(wr_data), .wr_last(wr_last), .bus(bus0), .bus_oe(oe[0]),
    .rd_data(rdd[0]), .rd_valid(rdv[0]), .burst_trunc(trunc[0]), .busy(busy[0]));

  tristate_bus_port #(.WIDTH(8), .TURN_CYCLES(0), .MAX_BURST(4)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready[1]),
    .wr_data(wr_data), .wr_last(wr_last), .bus(bus1), .bus_oe(oe[1]),
    .rd_data(rdd[1]), .rd_valid(rdv[1]), .burst_trunc(trunc[1]), .busy(busy[1]));

  tristate_bus_port #(.WIDTH(8), .TURN_CYCLES(3), .MAX_BURST(0)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready[2]),
    .wr_data(wr_data), .wr_last(wr_last), .bus(bus2), .bus_oe(oe[2]),
    .rd_data(rdd[2]), .rd_valid(rdv[2]), .burst_trunc(trunc[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bus_val(input int i);
    if (i == 0) return bus0;
    if (i == 1) return bus1;
    return bus2;
  endfunction

  function automatic bit m_term(input int i);
    return m_drv[i] && (m_last[i] || (mb[i] != 0 && m_beats[i] >= mb[i]));
  endfunction

  function automatic bit m_ready(input int i);
    return m_drv[i] ? !m_term(i) : (m_gap[i] == 0);
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < 3; i++)
      if (m_drv[i] || m_gap[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_drv[i] = 0; m_beats[i] = 0; m_last[i] = 0; m_data[i] = '0;
      m_gap[i] = 0; m_trunc[i] = 0; m_rdv[i] = 0; m_rdd[i] = '0; m_known[i] = 1;
      ext_en[i] = 0; ext_d[i] = '0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("oe%0d", i), 32'(oe[i]), 32'(m_drv[i]));
      chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(m_ready(i)));
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_drv[i] || m_gap[i] != 0));
      chk($sformatf("trunc%0d", i), 32'(trunc[i]), 32'(m_trunc[i]));
      chk($sformatf("rdvalid%0d", i), 32'(rdv[i]), 32'(m_rdv[i]));
      if (m_known[i]) chk($sformatf("rddata%0d", i), 32'(rdd[i]), 32'(m_rdd[i]));
      if (m_drv[i]) chk($sformatf("bus%0d", i), 32'(bus_val(i)), 32'(m_data[i]));
      else if (ext_en[i]) chk($sformatf("busext%0d", i), 32'(bus_val(i)), 32'(ext_d[i]));
    end
  endtask

  // Called at posedge+1: apply inputs, check at negedge, advance model at posedge.
  // ext_mode: 0 random external driver, 1 external drives 8'h5A, 2 none.
  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input int ext_mode);
    wr_valid = v; wr_data = d; wr_last = l;
    for (int i = 0; i < 3; i++) begin
      // External agent only drives when the port cannot start driving at the next edge.
      bit can = !m_drv[i] && !(m_gap[i] == 0 && v);
      ext_en[i] = can && (ext_mode == 1 || (ext_mode == 0 && $urandom_range(0, 1) == 1));
      ext_d[i]  = (ext_mode == 1) ? 8'h5A : 8'($urandom);
    end
    @(negedge clk);
    check_all();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      bit t = m_term(i);
      bit acc = v && m_ready(i);
      m_rdv[i] = !m_drv[i];
      if (m_drv[i]) begin m_rdd[i] = m_data[i]; m_known[i] = 1; end
      else if (ext_en[i]) begin m_rdd[i] = ext_d[i]; m_known[i] = 1; end
      else m_known[i] = 0;
      m_trunc[i] = 0;
      if (m_drv[i]) begin
        if (t) begin
          m_drv[i] = 0; m_gap[i] = tc[i]; m_trunc[i] = !m_last[i];
        end else if (acc) begin
          m_data[i] = d; m_beats[i]++; m_last[i] = l;
        end
      end else if (m_gap[i] > 0) begin
        m_gap[i]--;
      end else if (acc) begin
        m_drv[i] = 1; m_data[i] = d; m_beats[i] = 1; m_last[i] = l;
      end
    end
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (all_idle()) return;
      cycle(1'b0, 8'h00, 1'b0, 2);
    end
    chk("idle_timeout", 32'(all_idle()), 32'd1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 8'hA5; wr_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single beat with last
    cycle(1'b1, 8'h3C, 1'b1, 2);
    repeat (5) cycle(1'b0, 8'h00, 1'b0, 2);
    wait_idle();

    // Burst with a two-cycle stall
    cycle(1'b1, 8'h11, 1'b0, 2);
    cycle(1'b1, 8'h22, 1'b0, 2);
    cycle(1'b0, 8'hEE, 1'b1, 2);
    cycle(1'b0, 8'hEE, 1'b1, 2);
    cycle(1'b1, 8'h33, 1'b1, 2);
    repeat (6) cycle(1'b0, 8'h00, 1'b0, 2);
    wait_idle();

    // Continuous non-last beats: capped on the MAX_BURST=4 port
    for (int k = 0; k < 14; k++) cycle(1'b1, 8'($urandom), 1'b0, 2);
    cycle(1'b1, 8'h99, 1'b1, 2);
    wait_idle();

    // Back-to-back single-beat bursts
    for (int k = 0; k < 16; k++) cycle(1'b1, 8'($urandom), 1'b1, 2);
    wait_idle();

    // Readback of an external driver, then loopback of own data
    cycle(1'b0, 8'h00, 1'b0, 1);
    cycle(1'b0, 8'h00, 1'b0, 2);
    cycle(1'b1, 8'hC3, 1'b1, 2);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 2);
    wait_idle();

    // Asynchronous reset mid-DRIVE releases the bus without a clock edge
    cycle(1'b1, 8'h77, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_oe%0d", i), 32'(oe[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic
    for (int k = 0; k < 1500; k++)
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0, 0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/tristate_bus_port.md
Name: tristate_bus_port

Overview:
- Parametrised, registered, bidirectional tristate bus port; successor to the fixed 8-bit enable-gated buffer.
- Accepts write beats over a valid/ready handshake and drives them onto a shared tristate bus from a register.
- Enforces a programmable turnaround gap after each burst, caps burst length, and samples the bus while not driving.
- Sits between a local master and a shared multi-drop data bus.

Parameters:
- WIDTH, 8, bus and data width in bits (>=1).
- TURN_CYCLES, 1, Z-state dead cycles after a burst before the next beat may be accepted (0..15).
- MAX_BURST, 16, maximum beats per burst; the MAX_BURST-th beat is treated as last; 0 = unlimited.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write beat offered
- wr_ready  out  1  port can accept a beat this cycle
- wr_data  in  WIDTH  beat data
- wr_last  in  1  final beat of the burst
- bus  inout  WIDTH  shared tristate bus
- bus_oe  out  1  high while the port drives bus
- rd_data  out  WIDTH  registered bus sample
- rd_valid  out  1  rd_data was sampled while the port was not driving
- burst_trunc  out  1  one-cycle pulse when MAX_BURST forced a release
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, DRIVE, TURN. A beat is accepted at any edge where wr_valid & wr_ready are both high.
- Reset (asynchronous, immediate):
  - state=IDLE; bus=Z and bus_oe=0 with no clock required.
  - data_q=0, beat count=0, turn count=0.
  - rd_data=0, rd_valid=0, burst_trunc=0.
  - Reset asserted mid-DRIVE releases the bus at once; the burst is lost.
- bus = data_q on all bits when bus_oe=1, else all Z. bus_oe is a decode of the registered state (1 only in DRIVE); it is glitch-free.
- IDLE:
  - wr_ready=1.
  - Accept -> data_q<=wr_data, beat count<=1, state<=DRIVE.
  - Latency: the beat is on bus the cycle after acceptance.
- DRIVE:
  - The beat held in data_q is treated as terminal if its wr_last was 1, or if MAX_BURST!=0 and beat count==MAX_BURST.
  - wr_ready = not terminal.
  - Non-terminal beat, accept -> data_q updated, count+1; bus changes on the next cycle.
  - Non-terminal beat, no accept -> keep driving data_q (hold; no timeout).
  - Terminal beat is driven exactly one cycle, then state<=TURN (TURN_CYCLES>0) or IDLE (TURN_CYCLES=0). Turn count loads TURN_CYCLES.
  - burst_trunc pulses in the cycle after leaving DRIVE only if termination was caused by MAX_BURST while wr_last=0.
- TURN:
  - bus=Z, wr_ready=0.
  - Turn count decrements each cycle; state<=IDLE when it reaches 1.
  - The Z gap lasts exactly TURN_CYCLES cycles.
- TURN_CYCLES=0: a new beat may be accepted in the IDLE cycle right after the terminal beat, giving a 1-cycle Z gap (the minimum).
- Readback:
  - Every edge: rd_data<=bus, rd_valid<=(state==IDLE || state==TURN).
  - In DRIVE, rd_data still updates (loopback of own data) but rd_valid=0.
  - Z/X bits are captured as-is.
- wr_last on a non-accepted cycle is ignored.
- wr_data is only sampled at acceptance.
- Beat count saturates; it never wraps within a burst.

Test Plan:
- Reset: hold rst_n=0 with wr_valid=1, wr_data=8'hA5 -> bus=8'hZZ, bus_oe=0, rd_valid=0, wr_ready=1 after release. Assert rst_n=0 mid-DRIVE -> bus goes Z with no clock edge.
- Single beat, WIDTH=8, TURN_CYCLES=1: accept 8'h3C with wr_last=1 at edge 0 -> bus=8'h3C for exactly one cycle (edges 0-1), Z during TURN (edges 1-2), wr_ready=0 until edge 2, IDLE after.
- Burst with stall: beats 11,22,33(last), with wr_valid low for 2 cycles after 22 -> bus shows 11 for 1 cycle, 22 for 3 cycles, 33 for 1 cycle, then TURN_CYCLES Z cycles; burst_trunc=0.
- MAX_BURST=4: continuous wr_valid=1, wr_last=0 -> 4 beats driven, then release. burst_trunc pulses once, wr_ready=0 during the 4th beat and TURN, 5th beat accepted only after returning to IDLE.
- TURN_CYCLES=0 and 3: back-to-back single-beat bursts -> Z gap between driven beats of exactly 1 and 4 cycles respectively.
- Readback: an external driver forces bus=8'h5A while the port is in IDLE -> next cycle rd_data=8'h5A, rd_valid=1. During DRIVE of 8'hC3 -> rd_data=8'hC3, rd_valid=0.
